// File: rtl/y86_pipe_pkg.sv
// y86_pipe_pkg: Y86 status/icode codes and helpers for the pipeline bank.
package y86_pipe_pkg;

   localparam int STAT_W = 3;

   localparam logic [STAT_W-1:0] BUB = 3'd0;
   localparam logic [STAT_W-1:0] AOK = 3'd1;
   localparam logic [STAT_W-1:0] HLT = 3'd2;
   localparam logic [STAT_W-1:0] ADR = 3'd3;
   localparam logic [STAT_W-1:0] INS = 3'd4;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   function automatic logic is_exc(input logic [STAT_W-1:0] stat);
      return (stat == HLT) || (stat == ADR) || (stat == INS);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                           input logic        en);
      return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one pipeline register (payload, status, valid) with
// hold and bubble controls; reset loads a bubble.
module pipe_slot
   import y86_pipe_pkg::*;
#(
   parameter int          W          = 64,
   parameter logic [W-1:0] BUBBLE_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   input  logic              bubble_i,
   input  logic [W-1:0]      data_i,
   input  logic [STAT_W-1:0] stat_i,
   input  logic              valid_i,
   output logic [W-1:0]      data_o,
   output logic [STAT_W-1:0] stat_o,
   output logic              valid_o
);

   logic [W-1:0]      data_q, data_d;
   logic [STAT_W-1:0] stat_q, stat_d;
   logic              valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      stat_d  = stat_q;
      valid_d = valid_q;
      if (!hold_i) begin
         if (bubble_i) begin
            data_d  = BUBBLE_VAL;
            stat_d  = BUB;
            valid_d = 1'b0;
         end else begin
            data_d  = data_i;
            stat_d  = stat_i;
            valid_d = valid_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= BUBBLE_VAL;
         stat_q  <= BUB;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         stat_q  <= stat_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign stat_o  = stat_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/y86_pipe_bank.sv
// y86_pipe_bank: DEPTH-slot Y86 pipeline bank with stall back-propagation,
// auto-bubbles and sticky exception freeze. PIPE_PERF_EN enables counters.
module y86_pipe_bank
   import y86_pipe_pkg::*;
#(
   parameter int           W            = 64,
   parameter int           DEPTH        = 4,
   parameter logic [W-1:0] BUBBLE_VAL   = '0,
   parameter bit           FLUSH_ON_EXC = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [W-1:0]            in_data,
   input  logic [STAT_W-1:0]       in_stat,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DEPTH-1:0]        stall_req,
   input  logic [DEPTH-1:0]        bubble_req,
   output logic [DEPTH*W-1:0]      slot_data,
   output logic [DEPTH*STAT_W-1:0] slot_stat,
   output logic [DEPTH-1:0]        slot_valid,
   output logic                    frozen,
   output logic [31:0]             perf_stall,
   output logic [31:0]             perf_bubble,
   output logic [31:0]             perf_retire
);

   logic [DEPTH-1:0]  hold;
   logic [DEPTH-1:0]  auto_bub;
   logic              frozen_q, frozen_d;
   logic              flush;
   logic [W-1:0]      sd_q [DEPTH];
   logic [STAT_W-1:0] st_q [DEPTH];
   logic [DEPTH-1:0]  sv_q;

   // A slot holds if it or any later slot stalls, or the bank is frozen.
   always_comb begin
      hold = '0;
      for (int k = 0; k < DEPTH; k++) begin
         hold[k] = frozen_q | (|(stall_req >> k));
      end
   end

   assign flush    = FLUSH_ON_EXC & frozen_q;
   assign in_ready = ~hold[0];

   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      logic [W-1:0]      pd;
      logic [STAT_W-1:0] ps;
      logic              pv;
      logic              fl;

      if (k == 0) begin : g_head
         assign pd          = in_data;
         assign ps          = in_stat;
         assign pv          = in_valid;
         assign auto_bub[k] = 1'b0;
      end else begin : g_body
         assign pd          = sd_q[k-1];
         assign ps          = st_q[k-1];
         assign pv          = sv_q[k-1];
         assign auto_bub[k] = hold[k-1] & ~hold[k];
      end

      if (k == DEPTH-1) begin : g_tail
         assign fl = 1'b0;
      end else begin : g_front
         assign fl = flush;
      end

      pipe_slot #(
         .W          (W),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) u_slot (
         .clk_i    (clk),
         .rst_i    (reset),
         .hold_i   (hold[k] & ~fl),
         .bubble_i (bubble_req[k] | auto_bub[k] | fl),
         .data_i   (pd),
         .stat_i   (ps),
         .valid_i  (pv),
         .data_o   (sd_q[k]),
         .stat_o   (st_q[k]),
         .valid_o  (sv_q[k])
      );

      assign slot_data[k*W +: W]           = sd_q[k];
      assign slot_stat[k*STAT_W +: STAT_W] = st_q[k];
   end

   assign slot_valid = sv_q;

   assign frozen_d = frozen_q | is_exc(st_q[DEPTH-1]);

   always_ff @(posedge clk) begin
      if (reset) frozen_q <= 1'b0;
      else       frozen_q <= frozen_d;
   end

   assign frozen = frozen_q;

`ifdef PIPE_PERF_EN
   logic [31:0] stall_cnt_q, bub_cnt_q, ret_cnt_q;
   logic        any_bub, retire;

   assign any_bub = |(~hold & (bubble_req | auto_bub));
   assign retire  = ~hold[DEPTH-1] & sv_q[DEPTH-1]
                  & (st_q[DEPTH-1] == AOK);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         bub_cnt_q   <= '0;
         ret_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= sat_inc(stall_cnt_q, hold[0] & ~frozen_q);
         bub_cnt_q   <= sat_inc(bub_cnt_q, any_bub);
         ret_cnt_q   <= sat_inc(ret_cnt_q, retire);
      end
   end

   assign perf_stall  = stall_cnt_q;
   assign perf_bubble = bub_cnt_q;
   assign perf_retire = ret_cnt_q;
`else
   assign perf_stall  = '0;
   assign perf_bubble = '0;
   assign perf_retire = '0;
`endif

endmodule

// File: tb/tb_y86_pipe_bank.sv
// tb_y86_pipe_bank: table vectors, freeze/reset sequences and a randomized
// run against a slot-level reference model, for hold and flush variants.
module tb_y86_pipe_bank;

   localparam bit PERF =
`ifdef PIPE_PERF_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = '0;
   logic [2:0] in_stat = '0;
   logic       in_valid = 1'b0;
   logic [3:0] stall_req = '0;
   logic [3:0] bubble_req = '0;

   logic [31:0] sd [2];
   logic [11:0] ss [2];
   logic [3:0]  sv [2];
   logic        fz [2];
   logic        rdy [2];
   logic [31:0] ps [2];
   logic [31:0] pb [2];
   logic [31:0] pr [2];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   y86_pipe_bank #(
      .W(8), .DEPTH(4), .BUBBLE_VAL(8'h00), .FLUSH_ON_EXC(1'b0)
   ) u_hold (
      .clk(clk), .reset(reset), .in_data(in_data), .in_stat(in_stat),
      .in_valid(in_valid), .in_ready(rdy[0]), .stall_req(stall_req),
      .bubble_req(bubble_req), .slot_data(sd[0]), .slot_stat(ss[0]),
      .slot_valid(sv[0]), .frozen(fz[0]), .perf_stall(ps[0]),
      .perf_bubble(pb[0]), .perf_retire(pr[0])
   );

   y86_pipe_bank #(
      .W(8), .DEPTH(4), .BUBBLE_VAL(8'h00), .FLUSH_ON_EXC(1'b1)
   ) u_flush (
      .clk(clk), .reset(reset), .in_data(in_data), .in_stat(in_stat),
      .in_valid(in_valid), .in_ready(rdy[1]), .stall_req(stall_req),
      .bubble_req(bubble_req), .slot_data(sd[1]), .slot_stat(ss[1]),
      .slot_valid(sv[1]), .frozen(fz[1]), .perf_stall(ps[1]),
      .perf_bubble(pb[1]), .perf_retire(pr[1])
   );

   // reference model: one entry per instance (0 = hold, 1 = flush)
   logic [7:0]  md [2][4];
   logic [2:0]  ms [2][4];
   logic        mv [2][4];
   logic        mfz [2];
   logic [31:0] mps [2];
   logic [31:0] mpb [2];
   logic [31:0] mpr [2];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] sat(input logic [31:0] c,
                                       input logic e);
      if (e && c != 32'hFFFF_FFFF) return c + 1;
      return c;
   endfunction

   task automatic model_step(input int i);
      logic [7:0] nd [4];
      logic [2:0] nst [4];
      logic       nv [4];
      logic       h [4];
      logic       anyb, flush, fl, ab;
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            md[i][k] = '0; ms[i][k] = '0; mv[i][k] = 1'b0;
         end
         mfz[i] = 1'b0;
         mps[i] = '0; mpb[i] = '0; mpr[i] = '0;
         return;
      end
      flush = (i == 1) && mfz[i];
      for (int k = 0; k < 4; k++)
         h[k] = mfz[i] || ((stall_req >> k) != 0);
      anyb = 1'b0;
      for (int k = 0; k < 4; k++) begin
         fl = flush && (k < 3);
         ab = 1'b0;
         if (k > 0) ab = h[k-1] && !h[k];
         if (h[k] && !fl) begin
            nd[k] = md[i][k]; nst[k] = ms[i][k]; nv[k] = mv[i][k];
         end else if (bubble_req[k] || ab || fl) begin
            nd[k] = '0; nst[k] = '0; nv[k] = 1'b0;
            if (!h[k] && (bubble_req[k] || ab)) anyb = 1'b1;
         end else if (k == 0) begin
            nd[k] = in_data; nst[k] = in_stat; nv[k] = in_valid;
         end else begin
            nd[k] = md[i][k-1]; nst[k] = ms[i][k-1]; nv[k] = mv[i][k-1];
         end
      end
      if (PERF) begin
         mps[i] = sat(mps[i], h[0] && !mfz[i]);
         mpb[i] = sat(mpb[i], anyb);
         mpr[i] = sat(mpr[i], !h[3] && mv[i][3] && ms[i][3] == 3'd1);
      end
      mfz[i] = mfz[i] || (ms[i][3] inside {3'd2, 3'd3, 3'd4});
      for (int k = 0; k < 4; k++) begin
         md[i][k] = nd[k]; ms[i][k] = nst[k]; mv[i][k] = nv[k];
      end
   endtask

   function automatic logic [48:0] m_pack(input int i);
      logic [31:0] d;
      logic [11:0] s;
      logic [3:0]  v;
      for (int k = 0; k < 4; k++) begin
         d[k*8 +: 8] = md[i][k];
         s[k*3 +: 3] = ms[i][k];
         v[k]        = mv[i][k];
      end
      return {d, s, v, mfz[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   typedef struct {
      logic [7:0]  d;
      logic [3:0]  st;
      logic [3:0]  bu;
      logic        rdy;
      logic [31:0] ed;
      logic [3:0]  ev;
      int          eps;
      int          epb;
      int          epr;
   } vec_t;

   vec_t tbl [11];

   logic [31:0] snap_d [2];
   logic [11:0] snap_s [2];
   logic [3:0]  snap_v [2];
   logic [11:0] es;

   initial begin
      tbl[0]  = '{8'h11, 4'h0, 4'h0, 1'b1, 32'h0000_0011, 4'b0001, 0, 0, 0};
      tbl[1]  = '{8'h22, 4'h0, 4'h0, 1'b1, 32'h0000_1122, 4'b0011, 0, 0, 0};
      tbl[2]  = '{8'h33, 4'h0, 4'h0, 1'b1, 32'h0011_2233, 4'b0111, 0, 0, 0};
      tbl[3]  = '{8'hA0, 4'h0, 4'h0, 1'b1, 32'h1122_33A0, 4'b1111, 0, 0, 0};
      tbl[4]  = '{8'h44, 4'h1, 4'h0, 1'b0, 32'h2233_00A0, 4'b1101, 1, 1, 1};
      tbl[5]  = '{8'h44, 4'h0, 4'h0, 1'b1, 32'h3300_A044, 4'b1011, 1, 1, 2};
      tbl[6]  = '{8'h55, 4'h4, 4'h0, 1'b0, 32'h0000_A044, 4'b0011, 2, 2, 3};
      tbl[7]  = '{8'h55, 4'h4, 4'h0, 1'b0, 32'h0000_A044, 4'b0011, 3, 3, 3};
      tbl[8]  = '{8'h55, 4'h0, 4'h0, 1'b1, 32'h00A0_4455, 4'b0111, 3, 3, 3};
      tbl[9]  = '{8'h66, 4'h2, 4'h3, 1'b0, 32'hA000_4455, 4'b1011, 4, 4, 3};
      tbl[10] = '{8'h66, 4'h0, 4'h8, 1'b1, 32'h0044_5566, 4'b0111, 4, 5, 4};

      // reset state
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_data", sd[0], 32'h0);
      chk("rst_stat", ss[0], 12'h0);
      chk("rst_valid", sv[0], 4'h0);
      chk("rst_frozen", fz[0], 1'b0);
      chk("rst_perf", {ps[0], pb[0], pr[0]}, 96'h0);
      chk("rst_ready", rdy[0], 1'b1);

      // flow, load-use, back-propagation, hold-vs-bubble priority
      for (int i = 0; i < 11; i++) begin
         in_data    = tbl[i].d;
         in_stat    = 3'd1;
         in_valid   = 1'b1;
         stall_req  = tbl[i].st;
         bubble_req = tbl[i].bu;
         #1;
         chk($sformatf("tbl%0d_ready", i), rdy[0], tbl[i].rdy);
         tick();
         for (int k = 0; k < 4; k++)
            es[k*3 +: 3] = tbl[i].ev[k] ? 3'd1 : 3'd0;
         chk($sformatf("tbl%0d_data", i), sd[0], tbl[i].ed);
         chk($sformatf("tbl%0d_valid", i), sv[0], tbl[i].ev);
         chk($sformatf("tbl%0d_stat", i), ss[0], es);
         if (PERF)
            chk($sformatf("tbl%0d_perf", i), {ps[0], pb[0], pr[0]},
                {tbl[i].eps[31:0], tbl[i].epb[31:0], tbl[i].epr[31:0]});
         else
            chk($sformatf("tbl%0d_perf", i), {ps[0], pb[0], pr[0]}, 96'h0);
      end
      stall_req  = '0;
      bubble_req = '0;

      // exception freeze, both variants
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_data = 8'h5A; in_stat = 3'd2; in_valid = 1'b1;
      tick();
      in_stat = 3'd1;
      in_data = 8'h61; tick();
      in_data = 8'h62; tick();
      in_data = 8'h63; tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("frz%0d_arrive", i), sd[i], 32'h5A61_6263);
         chk($sformatf("frz%0d_hltstat", i), ss[i][11:9], 3'd2);
         chk($sformatf("frz%0d_notyet", i), fz[i], 1'b0);
      end
      in_data = 8'h64;
      tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("frz%0d_set", i), fz[i], 1'b1);
         snap_d[i] = sd[i]; snap_s[i] = ss[i]; snap_v[i] = sv[i];
      end
      in_data = 8'h77;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("frz_ready0", rdy[0], 1'b0);
         chk("frz_ready1", rdy[1], 1'b0);
         tick();
         chk("frz_hold", {sd[0], ss[0], sv[0], fz[0]},
             {snap_d[0], snap_s[0], snap_v[0], 1'b1});
         chk("frz_flush_tail", {sd[1][31:24], ss[1][11:9], sv[1][3]},
             {snap_d[1][31:24], snap_s[1][11:9], snap_v[1][3]});
         chk("frz_flush_front", {sd[1][23:0], ss[1][8:0], sv[1][2:0]},
             45'h0);
         chk("frz_flush_flag", fz[1], 1'b1);
      end

      // reset mid-freeze with a pending stall
      stall_req = 4'b0110;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      stall_req = '0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rfz%0d_state", i), {sd[i], ss[i], sv[i], fz[i]},
             49'h0);
         chk($sformatf("rfz%0d_perf", i), {ps[i], pb[i], pr[i]}, 96'h0);
         chk($sformatf("rfz%0d_ready", i), rdy[i], 1'b1);
      end

      // randomized run against the model
      reset = 1'b1;
      tick();
      for (int c = 0; c < 800; c++) begin
         int r;
         reset      = ($urandom_range(0, 49) == 0);
         stall_req  = 4'($urandom) & 4'($urandom) & 4'($urandom);
         bubble_req = 4'($urandom) & 4'($urandom);
         in_data    = 8'($urandom);
         in_valid   = 1'($urandom);
         r = $urandom_range(0, 79);
         in_stat = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : (r == 2) ? 3'd4 :
                   (r < 10) ? 3'd0 : (r == 10) ? 3'd6 : 3'd1;
         #1;
         for (int i = 0; i < 2; i++)
            chk($sformatf("rnd%0d_ready", i), rdy[i],
                !(mfz[i] || stall_req != 0));
         tick();
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("rnd%0d_state", i),
                {sd[i], ss[i], sv[i], fz[i]}, m_pack(i));
            chk($sformatf("rnd%0d_perf", i), {ps[i], pb[i], pr[i]},
                {mps[i], mpb[i], mpr[i]});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/y86_pipe_bank.md
Name: y86_pipe_bank

Overview:
- Parametrised bank of DEPTH pipeline slots for the Y86 pipeline: payload, 3-bit status and valid bit per slot.
- Replaces the hand-instantiated per-field stall/bubble registers.
- Adds automatic stall back-propagation, automatic bubble insertion behind a held slot, and a sticky exception freeze.
- Sits between fetch (slot 0 input) and write-back (slot DEPTH-1 output). The hazard unit drives the per-slot stall/bubble requests.

Parameters:
- W, 64, payload width per slot in bits.
- DEPTH, 4, number of slots; slot 0 = D, slot DEPTH-1 = W; minimum 2.
- BUBBLE_VAL, 0, W-bit payload loaded on bubble or reset.
- FLUSH_ON_EXC, 0, 1 = slots 0..DEPTH-2 load bubbles while frozen; 0 = they hold.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- in_data, input, W, payload entering slot 0.
- in_stat, input, 3, status entering slot 0.
- in_valid, input, 1, slot-0 input is a real instruction.
- in_ready, output, 1, equals ~hold[0]; slot 0 accepts this cycle.
- stall_req, input, DEPTH, per-slot hold request.
- bubble_req, input, DEPTH, per-slot bubble request.
- slot_data, output, DEPTH*W, flattened payloads, slot k at bits [k*W +: W].
- slot_stat, output, DEPTH*3, flattened statuses.
- slot_valid, output, DEPTH, per-slot valid.
- frozen, output, 1, sticky exception freeze.
- perf_stall, output, 32, stall-cycle counter.
- perf_bubble, output, 32, bubble-inserting-cycle counter.
- perf_retire, output, 32, retired-instruction counter.

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: every slot loads BUBBLE_VAL, stat BUB (0), valid 0. frozen=0, counters=0. Reset asserted mid-stall or mid-freeze overrides all other inputs that edge.
- Hold chain, combinational, computed from slot DEPTH-1 down to slot 0:
  - hold[DEPTH-1] = stall_req[DEPTH-1] | frozen.
  - hold[k] = stall_req[k] | hold[k+1], for k < DEPTH-1.
  - A held slot keeps its contents.
- Auto-bubble: for k ≥ 1, if hold[k-1] & ~hold[k], slot k loads a bubble (Y86 load-use: D holds, E bubbles).
- Per-slot priority each edge: reset > hold > (bubble_req[k] | auto-bubble) > load from predecessor. Slot 0's predecessor is in_data/in_stat/in_valid.
- Bubble contents: BUBBLE_VAL, stat BUB, valid 0.
- Latency: DEPTH edges from in_data to slot DEPTH-1 with no holds or bubbles.
- Freeze:
  - frozen is set on the edge after slot DEPTH-1 holds a stat in {HLT=2, ADR=3, INS=4}.
  - It stays set until reset.
  - While frozen, slot DEPTH-1 holds. Slots 0..DEPTH-2 hold, or flush to bubbles when FLUSH_ON_EXC=1. in_ready=0.
  - With FLUSH_ON_EXC=1, in_ready=0 also applies to flushed slots.
  - An exception status in a non-final slot does not freeze.
- stall_req and bubble_req on the same slot: hold wins.
- A bubble_req on a slot swallowed by a downstream hold: hold wins, so the request is lost. The hazard unit must re-assert it.
- All outputs are registered except in_ready.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined: counters are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
  - perf_stall increments each cycle hold[0] & ~frozen.
  - perf_bubble increments each cycle at least one slot loads a bubble (requested or auto), reset excluded.
  - perf_retire increments each edge slot DEPTH-1 advances (~hold[DEPTH-1]) while holding valid=1 and stat AOK.
- Not defined: counter ports remain and are tied to 0. No counter flops are synthesised.

Decomposition:
- Package y86_pipe_pkg:
  - stat codes BUB/AOK/HLT/ADR/INS and STAT_W=3;
  - icode constants IHALT..IPOPQ;
  - function is_exc(stat).
- Sub-module pipe_slot, parametrised on W:
  - one slot with data/stat/valid flops;
  - inputs hold, bubble, reset, plus predecessor values.
- y86_pipe_bank generates DEPTH pipe_slot instances plus the hold chain, freeze flop and counters.

Test Plan (DEPTH=4, W=8, BUBBLE_VAL=0):
- Flow: reset 1 cycle, then feed 0x11,0x22,0x33 with AOK, valid=1 on consecutive edges -> 0x11 at slot 3 on edge 4, then 0x22, 0x33; with PIPE_PERF_EN perf_retire=3 after 7 edges.
- Load-use: stall_req[0]=1 for one cycle with 0xA0 in slot 0 -> slot 0 keeps 0xA0; slot 1 gets BUB/valid 0; in_ready=0 that cycle; perf_stall=1, perf_bubble=1.
- Back-propagation: stall_req[2]=1 for 2 cycles -> slots 0..2 unchanged for 2 edges; slot 3 gets 2 bubbles; in_ready=0 both cycles.
- Hold vs bubble priority: stall_req[1]=1 and bubble_req[1]=1 together -> slot 1 holds; slot 2 auto-bubbles; bubble_req on slot 0 in the same cycle is ignored.
- Exception freeze: feed stat HLT with 0x5A -> 0x5A reaches slot 3, frozen=1 next edge; contents constant for 10 cycles; with FLUSH_ON_EXC=1, slots 0..2 become BUB.
- Reset mid-freeze: assert reset while frozen -> after one edge frozen=0, all slots BUB/0x00/valid 0, counters 0, in_ready=1.
